bias_add_sequencer: RTL and testbench
=====================================

# bias_add_sequencer

Sequences per-output-channel-group bias addition for one convolution layer. It sits between the adder-tree accumulator outputs and the activation stage. It steps a group index that drives the external bias-bank mux, latches the selected bias vector, and adds it lane-wise with saturation to a stream of accumulator results. It also counts pixels per group and signals layer completion.

## Interface
- N_adder_tree, 16, lanes per accumulator word (one bias per lane)
- DATA_W, 18, signed lane width, two's complement
- N_GROUPS, 40, output-channel groups per layer
- PIX_PER_GROUP, 196, accumulator words per group
- GROUP_W, 6, width of bias_sel; must satisfy 2^GROUP_W >= N_GROUPS
- PIX_W, 8, width of the pixel counter; must satisfy 2^PIX_W >= PIX_PER_GROUP
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a layer; ignored while busy=1
- acc_valid  in  1  accumulator word available
- acc_ready  out  1  block accepts the accumulator word this cycle
- acc_data  in  N_adder_tree*DATA_W  lane i at bits [DATA_W*(i+1)-1 : DATA_W*i]
- bias_sel  out  GROUP_W  registered group index driving the external bias-bank mux
- bias_q  in  N_adder_tree*DATA_W  bias vector from the mux; combinational function of bias_sel
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts the result
- out_data  out  N_adder_tree*DATA_W  saturated sums, same lane packing as acc_data
- busy  out  1  high from the start acceptance until the layer_done cycle, inclusive
- layer_done  out  1  one-cycle pulse when the last result is accepted downstream

## Operation
- **States:** IDLE, LOAD, RUN, FLUSH.
- **IDLE:**
  - On start: group←0, pix←0, bias_sel←0, busy←1, go to LOAD.
- **LOAD (exactly 1 cycle):**
  - Capture bias_q into bias_reg at the end of the cycle, then go to RUN.
  - acc_ready=0.
- **RUN:**
  - acc_ready = !out_valid || out_ready.
  - On acc handshake, for every lane i: out_data[i] ← sat(acc_data[i] + bias_reg[i]), out_valid←1.
  - Sum is computed at DATA_W+1 bits, then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. [-131072, 131071] at the defaults.
  - On handshake with pix == PIX_PER_GROUP-1: pix←0.
    - If group == N_GROUPS-1, go to FLUSH.
    - Otherwise group←group+1, bias_sel←group+1, go to LOAD.
  - Otherwise on handshake, pix←pix+1.
- **Output register:**
  - Cleared (out_valid←0) on out_ready when no new handshake occurs in the same cycle.
  - Holds its data and out_valid while out_ready=0.
  - A result already in the output register keeps the old group's sum while bias_reg reloads.
- **FLUSH:**
  - acc_ready=0.
  - Wait for out_valid && out_ready. In that cycle: layer_done=1, busy←0, out_valid←0, go to IDLE.
- **Reset:** asynchronous reset mid-layer aborts the layer. No layer_done is issued.

## Timing
- **Reset values:** state=IDLE, acc_ready=0, out_valid=0, out_data=0, bias_sel=0, busy=0, layer_done=0; counters and bias_reg are 0.
- **Start latency:** start at cycle T → LOAD in T+1 → acc_ready may be 1 in T+2.
- **Data latency:** 1 cycle from acc handshake to out_valid.
- **Throughput:** 1 word/cycle when out_ready=1. Each group boundary inserts exactly 1 bubble cycle (LOAD).
- **Layer length:** minimum N_GROUPS*(PIX_PER_GROUP+1)+2 cycles from start to layer_done.
- **Simultaneous out handshake and acc handshake:** the new result replaces the old one, and out_valid stays 1.
- **start while busy:** no effect.
- **start in the same cycle as layer_done:** ignored. The block returns to IDLE first.
- bias_sel changes only on LOAD entry. It is stable throughout RUN.

## Test plan
- **Basic add, group 0:** bias_q lane0 = 4796, acc lane0 = 1000, out_ready=1 → out_data lane0 = 5796 one cycle after the handshake.
- **Saturation:**
  - acc 131000 + bias 4796 → 131071.
  - acc -130000 + bias -8248 → -131072.
  - acc -5 + bias 3 → -2.
- **Group sequencing:** N_GROUPS=3, PIX_PER_GROUP=4, continuous acc_valid/out_ready:
  - bias_sel goes 0→1→2.
  - One acc_ready=0 cycle after every 4th handshake.
  - Exactly 12 outputs.
  - layer_done pulses once, in the cycle of the 12th acceptance.
- **Backpressure:** out_ready=0 for 5 cycles mid-group → acc_ready=0 and out_data held stable. Release → no word lost or duplicated; pix count continues.
- **Boundary backpressure:** out_ready=0 across the last word of group 0 → LOAD still occurs, the held out_data uses group-0 bias, and the next word uses group-1 bias.
- **Reset and ignored starts:**
  - rst_n low during RUN of group 1 → all outputs return to reset values immediately, and no layer_done is issued.
  - A new start afterwards restarts at bias_sel=0.
  - A start pulse issued during RUN is ignored.

Source files
------------

// File: rtl/bias_add_sequencer_if.sv
// rtl/bias_add_sequencer_if.sv - accumulator, bias-bank and result signals of the bias adder
// master: the sequencer; slave: the accumulator/bias-bank/activation side.
interface bias_add_sequencer_if #(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = 18,
  parameter int GROUP_W      = 6
);
  localparam int W = N_adder_tree * DATA_W;

  logic               acc_valid;
  logic               acc_ready;
  logic [W-1:0]       acc_data;
  logic [GROUP_W-1:0] bias_sel;
  logic [W-1:0]       bias_q;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;

  modport master (
    input  acc_valid, acc_data, bias_q, out_ready,
    output acc_ready, bias_sel, out_valid, out_data
  );

  modport slave (
    output acc_valid, acc_data, bias_q, out_ready,
    input  acc_ready, bias_sel, out_valid, out_data
  );
endinterface

// File: rtl/bias_add_sequencer.sv
// rtl/bias_add_sequencer.sv - per-group bias sequencing and lane-wise saturating add
// Steps the bias-bank group index, latches each group's bias vector and adds it to accumulator words.
module bias_add_sequencer #(
  parameter int N_adder_tree  = 16,
  parameter int DATA_W        = 18,
  parameter int N_GROUPS      = 40,
  parameter int PIX_PER_GROUP = 196,
  parameter int GROUP_W       = 6,
  parameter int PIX_W         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  bias_add_sequencer_if.master        bus,
  output logic                        busy_o,
  output logic                        layer_done_o
);
  localparam int W = N_adder_tree * DATA_W;
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(N_GROUPS - 1);
  localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(PIX_PER_GROUP - 1);
  localparam logic [DATA_W-1:0]  SAT_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]  SAT_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t             state_q;
  logic [GROUP_W-1:0] group_q;
  logic [PIX_W-1:0]   pix_q;
  logic [W-1:0]       bias_reg_q;
  logic               out_valid_q;
  logic [W-1:0]       out_data_q;
  logic               busy_q;

  logic               acc_hs;
  logic [W-1:0]       sat_sum_d;
  logic [DATA_W:0]    lane_sum;

  always_comb begin
    bus.acc_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
    acc_hs        = bus.acc_valid && bus.acc_ready;
    layer_done_o  = (state_q == S_FLUSH) && out_valid_q && bus.out_ready;
  end

  // Sign-extend both operands by one bit; the top two sum bits disagree exactly on overflow.
  always_comb begin
    sat_sum_d = '0;
    lane_sum  = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      lane_sum = {bus.acc_data[DATA_W*i + DATA_W-1], bus.acc_data[DATA_W*i +: DATA_W]}
               + {bias_reg_q[DATA_W*i + DATA_W-1],   bias_reg_q[DATA_W*i +: DATA_W]};
      if (lane_sum[DATA_W] != lane_sum[DATA_W-1]) begin
        sat_sum_d[DATA_W*i +: DATA_W] = lane_sum[DATA_W] ? SAT_MIN : SAT_MAX;
      end else begin
        sat_sum_d[DATA_W*i +: DATA_W] = lane_sum[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      group_q     <= '0;
      pix_q       <= '0;
      bias_reg_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // The output register is independent of the FSM so a held result survives a bias reload.
      if (acc_hs) begin
        out_data_q  <= sat_sum_d;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            group_q <= '0;
            pix_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          bias_reg_q <= bus.bias_q;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          if (acc_hs) begin
            if (pix_q == LAST_PIX) begin
              pix_q <= '0;
              if (group_q == LAST_GROUP) begin
                state_q <= S_FLUSH;
              end else begin
                group_q <= group_q + GROUP_W'(1);
                state_q <= S_LOAD;
              end
            end else begin
              pix_q <= pix_q + PIX_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (out_valid_q && bus.out_ready) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bias_sel  = group_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_bias_add_sequencer.sv
// tb/tb_bias_add_sequencer.sv - scoreboard bench for bias_add_sequencer
// Small layer geometry (3 groups x 4 words) so every group boundary and the flush are exercised.
module tb_bias_add_sequencer;
  localparam int NL    = 16;
  localparam int DW    = 18;
  localparam int NG    = 3;
  localparam int PPG   = 4;
  localparam int GW    = 2;
  localparam int PW    = 3;
  localparam int W     = NL * DW;
  localparam int TOTAL = NG * PPG;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic layer_done;

  bias_add_sequencer_if #(.N_adder_tree(NL), .DATA_W(DW), .GROUP_W(GW)) bif ();

  bias_add_sequencer #(
    .N_adder_tree(NL), .DATA_W(DW), .N_GROUPS(NG), .PIX_PER_GROUP(PPG), .GROUP_W(GW), .PIX_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bif), .busy_o(busy), .layer_done_o(layer_done)
  );

  logic [W-1:0] bank [0:(1<<GW)-1];
  logic [W-1:0] stim [0:TOTAL-1];
  logic [W-1:0] sb [$];
  int vectors = 0, miscompares = 0;
  int wcnt = 0, ocnt = 0, done_cnt = 0;

  assign bif.bias_q = bank[bif.bias_sel];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lane_of(input logic [W-1:0] v, input int i);
    logic signed [DW-1:0] x;
    x = v[i*DW +: DW];
    return int'(x);
  endfunction

  function automatic logic [DW-1:0] ref_lane(input int a, input int b);
    int s, hi, lo;
    hi = (1 << (DW-1)) - 1;
    lo = -(1 << (DW-1));
    s = a + b;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return DW'(s);
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] acc, input logic [W-1:0] bias);
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = ref_lane(lane_of(acc, i), lane_of(bias, i));
    return r;
  endfunction

  // Scoreboard: push on every accumulator handshake, pop on every downstream acceptance.
  always @(negedge clk) begin
    logic accept, exp_done;
    logic [W-1:0] exp_word;
    if (!rst_n) begin
      sb.delete();
      wcnt = 0;
      ocnt = 0;
    end else begin
      accept   = bif.out_valid && bif.out_ready;
      exp_done = accept && (ocnt == TOTAL - 1);
      vectors++;
      if (layer_done !== exp_done) begin
        miscompares++;
        $display("FAIL layer_done: got %b expected %b (accepted so far %0d)", layer_done, exp_done, ocnt);
      end
      if (layer_done) done_cnt++;
      if (accept) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL out_extra: got output %h expected none", bif.out_data);
        end else begin
          exp_word = sb.pop_front();
          if (bif.out_data !== exp_word) begin
            miscompares++;
            $display("FAIL out_data[%0d]: got %h expected %h", ocnt, bif.out_data, exp_word);
          end
        end
        ocnt++;
      end
      if (bif.acc_valid && bif.acc_ready) begin
        sb.push_back(ref_word(bif.acc_data, bank[(wcnt / PPG) % (1 << GW)]));
        wcnt++;
      end
    end
  end

  task automatic fill_stim();
    for (int k = 0; k < TOTAL; k++)
      for (int i = 0; i < NL; i++)
        case ($urandom_range(0, 7))
          0:       stim[k][i*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
          1:       stim[k][i*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
          default: stim[k][i*DW +: DW] = DW'($urandom);
        endcase
  endtask

  task automatic begin_layer();
    @(posedge clk); #1;
    wcnt = 0; ocnt = 0; done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_stream(input int first, input int n, output int sent);
    int guard, w0;
    sent = 0;
    guard = 0;
    while (sent < n && guard < 200) begin
      bif.acc_valid = 1'b1;
      bif.acc_data  = stim[first + sent];
      w0 = wcnt;
      @(negedge clk); #1;
      if (wcnt != w0) sent++;
      guard++;
      @(posedge clk); #1;
    end
    bif.acc_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output logic ok);
    int g;
    g = 0;
    while (done_cnt < target && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    bif.acc_valid = 1'b0; bif.acc_data = '0; bif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bif.acc_ready !== 1'b0) begin miscompares++; $display("FAIL rst_acc_ready: got %b expected 0", bif.acc_ready); end
    vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", bif.out_valid); end
    vectors++; if (bif.out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got %h expected 0", bif.out_data); end
    vectors++; if (bif.bias_sel !== '0) begin miscompares++; $display("FAIL rst_bias_sel: got %0d expected 0", bif.bias_sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (layer_done !== 1'b0) begin miscompares++; $display("FAIL rst_layer_done: got %b expected 0", layer_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sat();
    int expv [4] = '{5796, 131071, -131072, -2};
    int lanes[4] = '{0, 0, 1, 2};
    int g, w0, sent;
    logic ok;
    fill_stim();
    stim[0][0 +: DW]    = DW'(1000);
    stim[1][0 +: DW]    = DW'(131000);
    stim[2][DW +: DW]   = DW'(-130000);
    stim[3][2*DW +: DW] = DW'(-5);
    bif.out_ready = 1'b1;
    begin_layer();
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b expected 1", busy); end
    vectors++; if (bif.acc_ready !== 1'b0) begin miscompares++; $display("FAIL load_acc_ready: got %b expected 0", bif.acc_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      bif.acc_valid = 1'b1;
      bif.acc_data  = stim[k];
      w0 = wcnt;
      g = 0;
      do begin @(negedge clk); #1; g++; end while (wcnt == w0 && g < 20);
      if (k == 0) begin
        vectors++; if (g != 1) begin miscompares++; $display("FAIL start_latency: got handshake after %0d cycles expected 1", g); end
      end
      @(posedge clk); #1;
      bif.acc_valid = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (bif.out_valid !== 1'b1 || bif.out_data[lanes[k]*DW +: DW] !== DW'(expv[k])) begin
        miscompares++;
        $display("FAIL sat_word%0d: got valid %b lane%0d %0d expected valid 1 lane %0d", k, bif.out_valid, lanes[k], lane_of(bif.out_data, lanes[k]), expv[k]);
      end
      @(posedge clk); #1;
    end
    drive_stream(4, TOTAL - 4, sent);
    wait_done(1, ok);
    vectors++; if (sent != TOTAL - 4 || !ok) begin miscompares++; $display("FAIL basic_complete: got sent %0d done %b expected %0d 1", sent, ok, TOTAL - 4); end
    vectors++; if (ocnt != TOTAL || sb.size() != 0) begin miscompares++; $display("FAIL basic_count: got %0d outputs %0d pending expected %0d 0", ocnt, sb.size(), TOTAL); end
  endtask

  task automatic test_group_seq();
    int k, bubbles, done_c;
    fill_stim();
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    wcnt = 0; ocnt = 0; done_cnt = 0;
    start = 1'b1;
    bif.acc_valid = 1'b1;
    bif.acc_data  = stim[0];
    k = 0; bubbles = 0; done_c = -1;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge clk); #1;
      if (c >= 2 && k < TOTAL && !bif.acc_ready) bubbles++;
      if (wcnt != k) begin
        vectors++; if (c != 2 + k + k / PPG) begin miscompares++; $display("FAIL hs_cycle%0d: got cycle %0d expected %0d", k, c, 2 + k + k / PPG); end
        vectors++; if (bif.bias_sel !== GW'(k / PPG)) begin miscompares++; $display("FAIL bias_sel%0d: got %0d expected %0d", k, bif.bias_sel, k / PPG); end
        k = wcnt;
      end
      if (layer_done) done_c = c;
      @(posedge clk); #1;
      // Raise start in the cycle layer_done is due; it must be ignored.
      start = (c + 1 == NG * (PPG + 1) + 1);
      if (k < TOTAL) bif.acc_data = stim[k];
      else bif.acc_valid = 1'b0;
    end
    start = 1'b0;
    bif.acc_valid = 1'b0;
    vectors++; if (done_c + 1 != NG * (PPG + 1) + 2) begin miscompares++; $display("FAIL layer_len: got %0d cycles expected %0d", done_c + 1, NG * (PPG + 1) + 2); end
    vectors++; if (bubbles != NG - 1) begin miscompares++; $display("FAIL bubbles: got %0d expected %0d", bubbles, NG - 1); end
    vectors++; if (ocnt != TOTAL || done_cnt != 1) begin miscompares++; $display("FAIL seq_count: got %0d outputs %0d done expected %0d 1", ocnt, done_cnt, TOTAL); end
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_at_done: got busy %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int sent, g;
    logic ok;
    logic [W-1:0] held;
    fill_stim();
    bif.out_ready = 1'b1;
    begin_layer();
    fork
      drive_stream(0, TOTAL, sent);
      begin
        g = 0;
        while (wcnt < 6 && g < 100) begin @(negedge clk); #1; g++; end
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        held = ref_word(stim[5], bank[1]);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk); #1;
          vectors++; if (bif.acc_ready !== 1'b0) begin miscompares++; $display("FAIL bp_acc_ready%0d: got %b expected 0", j, bif.acc_ready); end
          vectors++; if (bif.out_valid !== 1'b1 || bif.out_data !== held) begin miscompares++; $display("FAIL bp_hold%0d: got %b %h expected 1 %h", j, bif.out_valid, bif.out_data, held); end
        end
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
      end
    join
    wait_done(1, ok);
    vectors++; if (sent != TOTAL || !ok) begin miscompares++; $display("FAIL bp_complete: got sent %0d done %b expected %0d 1", sent, ok, TOTAL); end
    vectors++; if (ocnt != TOTAL || sb.size() != 0) begin miscompares++; $display("FAIL bp_count: got %0d outputs %0d pending expected %0d 0", ocnt, sb.size(), TOTAL); end
  endtask

  task automatic test_boundary();
    int sent, g;
    logic ok;
    logic [W-1:0] held;
    fill_stim();
    bif.out_ready = 1'b1;
    begin_layer();
    fork
      drive_stream(0, TOTAL, sent);
      begin
        g = 0;
        while (wcnt < PPG && g < 100) begin @(negedge clk); #1; g++; end
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        held = ref_word(stim[PPG-1], bank[0]);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk); #1;
          vectors++; if (bif.out_data !== held) begin miscompares++; $display("FAIL bnd_hold%0d: got %h expected %h", j, bif.out_data, held); end
          vectors++; if (bif.bias_sel !== GW'(1) || bif.acc_ready !== 1'b0) begin miscompares++; $display("FAIL bnd_state%0d: got sel %0d ready %b expected 1 0", j, bif.bias_sel, bif.acc_ready); end
        end
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
      end
    join
    wait_done(1, ok);
    vectors++; if (sent != TOTAL || !ok || ocnt != TOTAL) begin miscompares++; $display("FAIL bnd_complete: got sent %0d done %b outputs %0d expected %0d 1 %0d", sent, ok, ocnt, TOTAL, TOTAL); end
  endtask

  task automatic test_reset_midlayer();
    int sent, g;
    logic ok;
    fill_stim();
    bif.out_ready = 1'b1;
    begin_layer();
    drive_stream(0, 6, sent);
    bif.out_ready = 1'b0;
    @(negedge clk); #1;
    vectors++; if (bif.bias_sel !== GW'(1) || bif.out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst: got sel %0d valid %b expected 1 1", bif.bias_sel, bif.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bif.acc_ready !== 1'b0 || bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_hs: got ready %b valid %b expected 0 0", bif.acc_ready, bif.out_valid); end
    vectors++; if (bif.out_data !== '0 || bif.bias_sel !== '0) begin miscompares++; $display("FAIL arst_data: got %h sel %0d expected 0 0", bif.out_data, bif.bias_sel); end
    vectors++; if (busy !== 1'b0 || layer_done !== 1'b0) begin miscompares++; $display("FAIL arst_status: got busy %b done %b expected 0 0", busy, layer_done); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL arst_no_done: got %0d expected 0", done_cnt); end
    begin_layer();
    @(negedge clk); #1;
    vectors++; if (bif.bias_sel !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL restart: got sel %0d busy %b expected 0 1", bif.bias_sel, busy); end
    @(posedge clk); #1;
    fork
      drive_stream(0, TOTAL, sent);
      begin
        g = 0;
        while (wcnt < 5 && g < 100) begin @(negedge clk); #1; g++; end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done(1, ok);
    vectors++; if (sent != TOTAL || !ok || ocnt != TOTAL) begin miscompares++; $display("FAIL restart_complete: got sent %0d done %b outputs %0d expected %0d 1 %0d", sent, ok, ocnt, TOTAL, TOTAL); end
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0 || done_cnt != 1) begin miscompares++; $display("FAIL busy_start_ignored: got busy %b done %0d expected 0 1", busy, done_cnt); end
  endtask

  initial begin
    for (int g = 0; g < (1 << GW); g++)
      for (int i = 0; i < NL; i++) bank[g][i*DW +: DW] = DW'($urandom);
    bank[0][0 +: DW]    = DW'(4796);
    bank[0][DW +: DW]   = DW'(-8248);
    bank[0][2*DW +: DW] = DW'(3);
    test_reset();
    test_basic_sat();
    test_group_seq();
    test_backpressure();
    test_boundary();
    test_reset_midlayer();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
